// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS main control FSM with mem_ready stalls on memory states
module mc_controller #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t state, next;
  logic ready, pcwrite, branch;
  assign ready = USE_MEM_READY ? mem_ready : 1'b1;
  assign pcen  = pcwrite | (branch & zero);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else       state <= next;
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:   next = ready ? DECODE : FETCH;
      DECODE:  next = (op == OP_LW || op == OP_SW) ? MEMADR :
                      (op == OP_R)    ? RTYPEEX :
                      (op == OP_BEQ)  ? BEQEX :
                      (op == OP_ADDI) ? ADDIEX :
                      (op == OP_J)    ? JEX : FETCH;
      MEMADR:  next = (op == OP_LW) ? MEMRD : (op == OP_SW) ? MEMWR : FETCH;
      MEMRD:   next = ready ? MEMWB : MEMRD;
      MEMWR:   next = ready ? FETCH : MEMWR;
      RTYPEEX: next = RTYPEWB;
      ADDIEX:  next = ADDIWB;
      default: next = FETCH;
    endcase
  end
  always_comb begin
    memwrite = 1'b0;
    irwrite  = 1'b0;
    iord     = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    illegal  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (state)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = ready;
        pcwrite = ready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = !(op == OP_LW || op == OP_SW || op == OP_R ||
                    op == OP_BEQ || op == OP_ADDI || op == OP_J);
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed checks of every instruction path, stalls and async reset
module tb_mc_controller;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = 6'b0;
  logic pcen, memwrite, irwrite, iord, regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [14:0] obs;
  int n_cmp = 0, n_err = 0;
  // {pcen,memwrite,irwrite,iord,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,aluop,illegal}
  localparam logic [14:0] W_FETCH_RDY = 15'b1_0_1_0_0_0_0_0_01_00_00_0;
  localparam logic [14:0] W_FETCH_WT  = 15'b0_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [14:0] W_DECODE    = 15'b0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [14:0] W_DEC_ILL   = 15'b0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [14:0] W_MEMADR    = 15'b0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [14:0] W_MEMRD     = 15'b0_0_0_1_0_0_0_0_00_00_00_0;
  localparam logic [14:0] W_MEMWB     = 15'b0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [14:0] W_MEMWR     = 15'b0_1_0_1_0_0_0_0_00_00_00_0;
  localparam logic [14:0] W_RTYPEEX   = 15'b0_0_0_0_0_0_0_1_00_00_10_0;
  localparam logic [14:0] W_RTYPEWB   = 15'b0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [14:0] W_BEQ_Z     = 15'b1_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [14:0] W_BEQ_NZ    = 15'b0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [14:0] W_ADDIWB    = 15'b0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [14:0] W_JEX       = 15'b1_0_0_0_0_0_0_0_00_10_00_0;
  mc_controller #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .iord(iord),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal)
  );
  assign obs = {pcen, memwrite, irwrite, iord, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, aluop, illegal};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [14:0] exp);
    #1;
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  initial begin
    #2;
    chk("reset_outputs", W_FETCH_WT);
    reset = 1'b0;
    op = 6'b100011;
    chk("fetch_stall", W_FETCH_WT);
    tick;
    chk("fetch_still_stalled", W_FETCH_WT);
    mem_ready = 1'b1;
    chk("lw_c1_fetch", W_FETCH_RDY);
    tick; chk("lw_c2_decode", W_DECODE);
    tick; chk("lw_c3_memadr", W_MEMADR);
    tick; mem_ready = 1'b0; chk("lw_c4_memrd_wait", W_MEMRD);
    tick; chk("lw_memrd_stalled", W_MEMRD);
    mem_ready = 1'b1;
    chk("lw_memrd_ready", W_MEMRD);
    tick; chk("lw_c5_memwb", W_MEMWB);
    tick; op = 6'b101011; chk("sw_c1_fetch", W_FETCH_RDY);
    tick; chk("sw_c2_decode", W_DECODE);
    tick; chk("sw_c3_memadr", W_MEMADR);
    tick; mem_ready = 1'b0; chk("sw_memwr_w1", W_MEMWR);
    tick; chk("sw_memwr_w2", W_MEMWR);
    tick; chk("sw_memwr_w3", W_MEMWR);
    tick; mem_ready = 1'b1; chk("sw_memwr_w4", W_MEMWR);
    tick; op = 6'b000000; chk("r_c1_fetch", W_FETCH_RDY);
    tick; chk("r_c2_decode", W_DECODE);
    tick; chk("r_c3_rtypeex", W_RTYPEEX);
    tick; chk("r_c4_rtypewb", W_RTYPEWB);
    tick; op = 6'b000100; zero = 1'b1; chk("beq_c1_fetch", W_FETCH_RDY);
    tick; chk("beq_c2_decode", W_DECODE);
    tick; chk("beq_c3_taken", W_BEQ_Z);
    zero = 1'b0;
    chk("beq_c3_not_taken", W_BEQ_NZ);
    tick; op = 6'b001000; chk("addi_c1_fetch", W_FETCH_RDY);
    tick; chk("addi_c2_decode", W_DECODE);
    tick; chk("addi_c3_addiex", W_MEMADR);
    tick; chk("addi_c4_addiwb", W_ADDIWB);
    tick; op = 6'b000010; chk("j_c1_fetch", W_FETCH_RDY);
    tick; chk("j_c2_decode", W_DECODE);
    tick; chk("j_c3_jex", W_JEX);
    tick; op = 6'b111111; chk("ill_c1_fetch", W_FETCH_RDY);
    tick; chk("ill_c2_decode", W_DEC_ILL);
    tick; chk("ill_back_fetch", W_FETCH_RDY);
    op = 6'b100011;
    tick; chk("abort_decode", W_DECODE);
    tick; chk("abort_memadr", W_MEMADR);
    tick; chk("abort_memrd", W_MEMRD);
    mem_ready = 1'b0;
    reset = 1'b1;
    chk("abort_async_reset", W_FETCH_WT);
    tick; chk("abort_reset_held", W_FETCH_WT);
    reset = 1'b0;
    mem_ready = 1'b1;
    chk("abort_fetch_ready", W_FETCH_RDY);
    tick; chk("abort_restart_decode", W_DECODE);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
